hex_key_entry: RTL and testbench



---
 rtl/hex_key_entry.sv | 135 +++++++++++++
 tb/tb_hex_key_entry.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_key_entry.sv
// rtl/hex_key_entry.sv - debounced hex keypad entry with valid/ready commit output
// Optional HEX_KEY_ENTRY_AUTOCOMMIT_EN: the eighth digit commits the word without an ok press.
module hex_key_entry #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic        btn_del,
  input  logic        btn_ok,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [31:0] entry_data,
  output logic [3:0]  digit_cnt
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {ST_PRIME, ST_LOAD, ST_RUN} arm_state_t;

  arm_state_t state, state_next;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [17:0]   raw, sync1, sync2, prev_smp, stable, stable_old;
  logic [17:0]   agree;
  logic          upd;

  logic          ev_ok, ev_del, ev_digit;
  logic [15:0]   sw_diff;
  logic [3:0]    digit;
  logic [31:0]   entry_shift;

  assign raw   = {btn_ok, btn_del, sw};
  assign tick  = (tick_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign agree = ~(sync2 ^ prev_smp);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_PRIME;
    else     state <= state_next;
  end

  // Two ticks are spent arming so inputs held through reset never look like edges.
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        ST_PRIME: state_next = ST_LOAD;
        ST_LOAD:  state_next = ST_RUN;
        default:  state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      tick_cnt   <= '0;
      prev_smp   <= '0;
      stable     <= '0;
      stable_old <= '0;
      upd        <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      upd      <= 1'b0;
      if (tick) begin
        prev_smp <= sync2;
        case (state)
          ST_PRIME: ;
          ST_LOAD:  stable <= sync2;
          default: begin
            stable_old <= stable;
            stable     <= (sync2 & agree) | (stable & ~agree);
            upd        <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    ev_ok       = upd & stable[17] & ~stable_old[17];
    ev_del      = upd & stable[16] & ~stable_old[16];
    sw_diff     = (stable[15:0] ^ stable_old[15:0]) & {16{upd}};
    ev_digit    = |sw_diff;
    digit       = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (sw_diff[i]) digit = 4'(i);
    end
    entry_shift = {entry_data[27:0], digit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      entry_data <= '0;
      digit_cnt  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // An ok event consumes the cycle even when it is ignored for a pending word.
      if (ev_ok) begin
        if (!out_valid) begin
          out_data   <= entry_data;
          out_valid  <= 1'b1;
          entry_data <= '0;
          digit_cnt  <= '0;
        end
      end else if (ev_del) begin
        entry_data <= entry_data >> 4;
        digit_cnt  <= (digit_cnt == 4'd0) ? 4'd0 : digit_cnt - 4'd1;
      end else if (ev_digit) begin
`ifdef HEX_KEY_ENTRY_AUTOCOMMIT_EN
        if (digit_cnt == 4'd7 && !out_valid) begin
          out_data   <= entry_shift;
          out_valid  <= 1'b1;
          entry_data <= '0;
          digit_cnt  <= '0;
        end else begin
          entry_data <= entry_shift;
          digit_cnt  <= (digit_cnt >= 4'd8) ? 4'd8 : digit_cnt + 4'd1;
        end
`else
        entry_data <= entry_shift;
        digit_cnt  <= (digit_cnt >= 4'd8) ? 4'd8 : digit_cnt + 4'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hex_key_entry.sv
// tb/tb_hex_key_entry.sv - self-checking bench for hex_key_entry with a keypad-level reference model
module tb_hex_key_entry;

  localparam int DEB  = 4;
  localparam int HOLD = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw = '0;
  logic        btn_del = 1'b0;
  logic        btn_ok = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [31:0] entry_data;
  logic [3:0]  digit_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_entry, m_data;
  logic [3:0]  m_cnt;
  logic        m_valid;

  hex_key_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_del(btn_del), .btn_ok(btn_ok),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .entry_data(entry_data), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_entry = '0; m_data = '0; m_cnt = '0; m_valid = 1'b0;
  endtask

  // Apply a held input change to the model, then hold it long enough to be debounced.
  task automatic drive(input logic [15:0] s, input logic d, input logic o);
    logic [15:0] diff;
    int dg;
    diff = sw ^ s;
    if (o && !btn_ok) begin
      if (!m_valid) begin
        m_data = m_entry; m_valid = 1'b1; m_entry = '0; m_cnt = '0;
      end
    end else if (d && !btn_del) begin
      m_entry = m_entry / 16;
      m_cnt   = (m_cnt == 0) ? 4'd0 : m_cnt - 4'd1;
    end else if (diff != 0) begin
      dg = 0;
      for (int i = 15; i >= 0; i--) if (diff[i]) dg = i;
`ifdef HEX_KEY_ENTRY_AUTOCOMMIT_EN
      if (m_cnt == 7 && !m_valid) begin
        m_data = m_entry * 16 + dg; m_valid = 1'b1; m_entry = '0; m_cnt = '0;
      end else begin
        m_entry = m_entry * 16 + dg;
        m_cnt   = (m_cnt == 8) ? 4'd8 : m_cnt + 4'd1;
      end
`else
      m_entry = m_entry * 16 + dg;
      m_cnt   = (m_cnt == 8) ? 4'd8 : m_cnt + 4'd1;
`endif
    end
    sw = s; btn_del = d; btn_ok = o;
    step(HOLD);
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    step(3);
    tests++;
    if ({out_valid, out_data, digit_cnt, entry_data} !== 69'd0) begin
      fails++;
      $display("FAIL reset_in: got v=%b d=%h c=%0d e=%h expected all zero", out_valid, out_data, digit_cnt, entry_data);
    end
    rst = 1'b0;
    step(20);
    tests++;
    if ({out_valid, out_data, digit_cnt, entry_data} !== 69'd0) begin
      fails++;
      $display("FAIL reset_after: got v=%b d=%h c=%0d e=%h expected all zero", out_valid, out_data, digit_cnt, entry_data);
    end
  endtask

  task automatic test_digits();
    drive(sw ^ 16'h0008, 1'b0, 1'b0);
    drive(sw ^ 16'h0400, 1'b0, 1'b0);
    tests++;
    if (entry_data !== 32'h3A || digit_cnt !== 4'd2 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL digits_3A: got e=%h c=%0d v=%b expected e=0000003a c=2 v=0", entry_data, digit_cnt, out_valid);
    end
  endtask

  task automatic test_delete();
    logic [31:0] exp_e [3];
    logic [3:0]  exp_c [3];
    exp_e = '{32'h3, 32'h0, 32'h0};
    exp_c = '{4'd1, 4'd0, 4'd0};
    for (int k = 0; k < 3; k++) begin
      drive(sw, 1'b1, 1'b0);
      drive(sw, 1'b0, 1'b0);
      tests++;
      if (entry_data !== exp_e[k] || digit_cnt !== exp_c[k]) begin
        fails++;
        $display("FAIL delete_%0d: got e=%h c=%0d expected e=%h c=%0d", k, entry_data, digit_cnt, exp_e[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_fill_commit();
    for (int i = 1; i <= 9; i++) drive(sw ^ (16'h1 << i), 1'b0, 1'b0);
    tests++;
    if ({out_valid, out_data, digit_cnt, entry_data} !== {m_valid, m_data, m_cnt, m_entry}) begin
      fails++;
      $display("FAIL fill9: got v=%b d=%h c=%0d e=%h expected v=%b d=%h c=%0d e=%h",
               out_valid, out_data, digit_cnt, entry_data, m_valid, m_data, m_cnt, m_entry);
    end
    if (!m_valid) drive(sw, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      tests++;
      if (out_valid !== 1'b1 || out_data !== m_data || entry_data !== m_entry) begin
        fails++;
        $display("FAIL hold_%0d: got v=%b d=%h e=%h expected v=1 d=%h e=%h", i, out_valid, out_data, entry_data, m_data, m_entry);
      end
    end
    drive(sw, 1'b0, 1'b0);
    pulse_ready();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL transfer_drop: got v=%b expected v=0", out_valid);
    end
  endtask

  task automatic test_pending();
    drive(sw ^ 16'h0080, 1'b0, 1'b0);
    drive(sw, 1'b0, 1'b1);
    drive(sw, 1'b0, 1'b0);
    drive(sw ^ 16'h0020, 1'b0, 1'b0);
    drive(sw, 1'b0, 1'b1);
    drive(sw, 1'b0, 1'b0);
    tests++;
    if (out_data !== 32'h7 || out_valid !== 1'b1 || entry_data !== 32'h5) begin
      fails++;
      $display("FAIL pending_ok: got d=%h v=%b e=%h expected d=00000007 v=1 e=00000005", out_data, out_valid, entry_data);
    end
    pulse_ready();
    drive(sw, 1'b0, 1'b1);
    drive(sw, 1'b0, 1'b0);
    tests++;
    if (out_data !== 32'h5 || out_valid !== 1'b1 || digit_cnt !== 4'd0) begin
      fails++;
      $display("FAIL commit5: got d=%h v=%b c=%0d expected d=00000005 v=1 c=0", out_data, out_valid, digit_cnt);
    end
    pulse_ready();
    drive(sw, 1'b0, 1'b1);
    drive(sw, 1'b0, 1'b0);
    tests++;
    if (out_data !== 32'h0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL commit_empty: got d=%h v=%b expected d=00000000 v=1", out_data, out_valid);
    end
    pulse_ready();
  endtask

  task automatic test_glitch_priority();
    sw[7] = ~sw[7];
    step(2);
    sw[7] = ~sw[7];
    step(HOLD);
    tests++;
    if ({out_valid, out_data, digit_cnt, entry_data} !== {m_valid, m_data, m_cnt, m_entry}) begin
      fails++;
      $display("FAIL glitch: got c=%0d e=%h expected c=%0d e=%h", digit_cnt, entry_data, m_cnt, m_entry);
    end
    drive(sw ^ 16'h0003, 1'b0, 1'b0);
    drive(sw ^ 16'h0010, 1'b0, 1'b1);
    drive(sw, 1'b0, 1'b0);
    tests++;
    if ({out_valid, out_data, digit_cnt, entry_data} !== {m_valid, m_data, m_cnt, m_entry}) begin
      fails++;
      $display("FAIL ok_over_digit: got v=%b d=%h c=%0d e=%h expected v=%b d=%h c=%0d e=%h",
               out_valid, out_data, digit_cnt, entry_data, m_valid, m_data, m_cnt, m_entry);
    end
    pulse_ready();
    drive(sw ^ 16'h0204, 1'b0, 1'b0);
    tests++;
    if (entry_data !== 32'h2 || digit_cnt !== 4'd1) begin
      fails++;
      $display("FAIL lowest_digit: got e=%h c=%0d expected e=00000002 c=1", entry_data, digit_cnt);
    end
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: drive(sw ^ (16'h1 << $urandom_range(0, 15)), 1'b0, 1'b0);
        1: drive(sw ^ (16'h1 << $urandom_range(0, 15)) ^ (16'h1 << $urandom_range(0, 15)), 1'b0, 1'b0);
        2: begin drive(sw, 1'b1, 1'b0); drive(sw, 1'b0, 1'b0); end
        3: begin drive(sw, 1'b0, 1'b1); drive(sw, 1'b0, 1'b0); end
        default: begin pulse_ready(); step(2); end
      endcase
      tests++;
      if ({out_valid, out_data, digit_cnt, entry_data} !== {m_valid, m_data, m_cnt, m_entry}) begin
        fails++;
        $display("FAIL random_%0d op%0d: got v=%b d=%h c=%0d e=%h expected v=%b d=%h c=%0d e=%h",
                 n, op, out_valid, out_data, digit_cnt, entry_data, m_valid, m_data, m_cnt, m_entry);
      end
    end
    if (m_valid) pulse_ready();
  endtask

  task automatic test_reset_held();
    drive(sw ^ 16'h0400, 1'b0, 1'b0);
    drive(sw ^ 16'h0800, 1'b0, 1'b0);
    sw[2] = 1'b1;
    btn_ok = 1'b1;
    rst = 1'b1;
    model_reset();
    step(3);
    rst = 1'b0;
    step(40);
    tests++;
    if ({out_valid, out_data, digit_cnt, entry_data} !== 69'd0) begin
      fails++;
      $display("FAIL held_reset: got v=%b d=%h c=%0d e=%h expected all zero", out_valid, out_data, digit_cnt, entry_data);
    end
    drive(sw, 1'b0, 1'b0);
    tests++;
    if ({out_valid, digit_cnt, entry_data} !== 37'd0) begin
      fails++;
      $display("FAIL held_ok_release: got v=%b c=%0d e=%h expected all zero", out_valid, digit_cnt, entry_data);
    end
    drive(sw & ~16'h0004, 1'b0, 1'b0);
    tests++;
    if (entry_data !== 32'h2 || digit_cnt !== 4'd1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL held_sw_change: got e=%h c=%0d v=%b expected e=00000002 c=1 v=0", entry_data, digit_cnt, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_delete();
    test_fill_commit();
    test_pending();
    test_glitch_priority();
    test_random();
    test_reset_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
